// File: rtl/room_thermal_model.sv
// room_thermal_model
// ------------------
// Behavioural plant model of a room, used to close the loop around the AC
// controller. The controller's heat/cool commands pick a mode. A prescaler
// then moves the room temperature one degree per mode period:
//   HEAT  : +1 C every HEAT_PERIOD edges, saturating at 31
//   COOL  : -1 C every COOL_PERIOD edges, saturating at 0
//   DRIFT : 1 C toward AMBIENT_TEMP every DRIFT_PERIOD edges
//   FAULT : both commands at once; temperature holds and fault is raised
//
// Ports
//   clk         in   system clock, rising edge
//   rst         in   asynchronous active-high reset
//   heating     in   heat command
//   cooling     in   cool command
//   temperature out  registered room temperature, unsigned deg C (5 bits)
//   step        out  one-cycle pulse after each edge that changed temperature
//   fault       out  registered, high while both commands are asserted
//   mode        out  current mode state (DRIFT/HEAT/COOL/FAULT), for
//                    observation only
//
// Optional build macro THERMAL_NOISE_EN: adds an 8-bit Fibonacci LFSR
// (taps 8,6,5,4, seed 8'hA5). Each DRIFT step opportunity then moves the
// temperature only when lfsr[0] is 1. HEAT and COOL are unaffected.
//
// Handshake: there is none. The commands are level-sensitive and are
// sampled on every rising edge. No output depends combinationally on an
// input.

module room_thermal_model #(
  parameter logic [4:0] INIT_TEMP    = 5'd18,
  parameter logic [4:0] AMBIENT_TEMP = 5'd15,
  parameter logic [7:0] HEAT_PERIOD  = 8'd8,
  parameter logic [7:0] COOL_PERIOD  = 8'd8,
  parameter logic [7:0] DRIFT_PERIOD = 8'd32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       heating,
  input  logic       cooling,
  output logic [4:0] temperature,
  output logic       step,
  output logic       fault,
  output logic [1:0] mode
);

  typedef enum logic [1:0] {
    DRIFT = 2'd0,
    HEAT  = 2'd1,
    COOL  = 2'd2,
    FAULT = 2'd3
  } mode_t;

  mode_t      mode_q;
  mode_t      mode_d;
  logic [7:0] cnt;
  logic [7:0] period;
  logic [4:0] target;
  logic       moves;
  logic       drift_ok;

  assign mode = mode_q;

  // Decode the commands into the mode requested for this edge.
  always_comb begin
    mode_d = DRIFT;
    case ({heating, cooling})
      2'b10:   mode_d = HEAT;
      2'b01:   mode_d = COOL;
      2'b11:   mode_d = FAULT;
      default: mode_d = DRIFT;
    endcase
  end

  // Prescaler period of the mode that is currently latched.
  always_comb begin
    period = DRIFT_PERIOD;
    case (mode_q)
      HEAT:    period = HEAT_PERIOD;
      COOL:    period = COOL_PERIOD;
      default: period = DRIFT_PERIOD;
    endcase
  end

`ifdef THERMAL_NOISE_EN
  logic [7:0] lfsr_q;

  // Fibonacci LFSR with taps 8,6,5,4. It advances on every edge,
  // whatever the mode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= 8'hA5;
    end else begin
      lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
  end

  assign drift_ok = lfsr_q[0];
`else
  assign drift_ok = 1'b1;
`endif

  // Work out the temperature a step would produce. A step that would not
  // change the value (a saturated value, or already at ambient) does not
  // count as a move, so step stays low for it.
  always_comb begin
    target = temperature;
    moves  = 1'b0;
    case (mode_q)
      HEAT: begin
        if (temperature != 5'd31) begin
          target = temperature + 5'd1;
          moves  = 1'b1;
        end
      end
      COOL: begin
        if (temperature != 5'd0) begin
          target = temperature - 5'd1;
          moves  = 1'b1;
        end
      end
      DRIFT: begin
        if (drift_ok && (temperature < AMBIENT_TEMP)) begin
          target = temperature + 5'd1;
          moves  = 1'b1;
        end else if (drift_ok && (temperature > AMBIENT_TEMP)) begin
          target = temperature - 5'd1;
          moves  = 1'b1;
        end
      end
      default: begin
        target = temperature;
        moves  = 1'b0;
      end
    endcase
  end

  // Mode FSM and prescaler. Any change in the decoded mode restarts the
  // prescaler, so command glitches faster than the period freeze the
  // temperature.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q      <= DRIFT;
      cnt         <= 8'd0;
      temperature <= INIT_TEMP;
      step        <= 1'b0;
      fault       <= 1'b0;
    end else begin
      step  <= 1'b0;
      fault <= (mode_d == FAULT);
      if (mode_d != mode_q) begin
        mode_q <= mode_d;
        cnt    <= 8'd0;
      end else if ((mode_q != FAULT) && (cnt == period - 8'd1)) begin
        cnt <= 8'd0;
        if (moves) begin
          temperature <= target;
          step        <= 1'b1;
        end
      end else if (mode_q != FAULT) begin
        cnt <= cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_room_thermal_model.sv
// Testbench for room_thermal_model: a table of directed vectors, hand
// sequences for the corner cases, and random command segments compared
// every cycle against a reference model of the room.

module tb_room_thermal_model;

  localparam int INIT_T = 18;
  localparam int AMB_T  = 15;
  localparam int P_HEAT = 8;
  localparam int P_COOL = 8;
  localparam int P_DRFT = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       heating = 1'b0;
  logic       cooling = 1'b0;
  logic [4:0] temperature;
  logic       step;
  logic       fault;
  logic [1:0] mode;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model. Time in a mode is counted as the number of edges since
  // the mode was latched. A step falls due whenever that count reaches a
  // whole multiple of the mode's period.
  int         m_temp;
  int         m_mode;      // 0 drift, 1 heat, 2 cool, 3 fault
  int         m_elapsed;
  bit         m_step;
  bit         m_fault;
  logic [7:0] m_lfsr;
  logic [4:0] exp_q[$];

  typedef struct {
    bit h;
    bit c;
    int n;
    int t;
    bit s;
    bit f;
  } vec_t;

  vec_t tbl[$];

  room_thermal_model dut (
    .clk         (clk),
    .rst         (rst),
    .heating     (heating),
    .cooling     (cooling),
    .temperature (temperature),
    .step        (step),
    .fault       (fault),
    .mode        (mode)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_temp    = INIT_T;
    m_mode    = 0;
    m_elapsed = 0;
    m_step    = 1'b0;
    m_fault   = 1'b0;
    m_lfsr    = 8'hA5;
    exp_q.delete();
  endtask

  task automatic model_edge(input bit h, input bit c);
    int dec;
    int per;
    bit moved;
    dec   = (h && c) ? 3 : h ? 1 : c ? 2 : 0;
    moved = 1'b0;
    if (dec != m_mode) begin
      m_mode    = dec;
      m_elapsed = 0;
    end else if (m_mode != 3) begin
      m_elapsed++;
      per = (m_mode == 1) ? P_HEAT : (m_mode == 2) ? P_COOL : P_DRFT;
      if (m_elapsed % per == 0) begin
        if (m_mode == 1 && m_temp < 31) begin
          m_temp++;
          moved = 1'b1;
        end else if (m_mode == 2 && m_temp > 0) begin
          m_temp--;
          moved = 1'b1;
        end else if (m_mode == 0) begin
`ifdef THERMAL_NOISE_EN
          if (m_lfsr[0]) begin
`else
          begin
`endif
            if (m_temp < AMB_T) begin
              m_temp++;
              moved = 1'b1;
            end else if (m_temp > AMB_T) begin
              m_temp--;
              moved = 1'b1;
            end
          end
        end
      end
    end
    m_step  = moved;
    m_fault = (m_mode == 3);
    m_lfsr  = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    exp_q.push_back(5'(m_temp));
  endtask

  // Driver: hold the commands for n edges. After each edge, compare the
  // outputs with the model on the falling edge.
  task automatic run(input bit h, input bit c, input int n);
    logic [4:0] e;
    for (int i = 0; i < n; i++) begin
      heating = h;
      cooling = c;
      @(posedge clk);
      model_edge(h, c);
      @(negedge clk);
      e = exp_q.pop_front();
      check("model_temp", temperature, e);
      check("model_step", step, m_step);
      check("model_fault", fault, m_fault);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    heating = 1'b0;
    cooling = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("reset_temp", temperature, INIT_T);
    check("reset_step", step, 0);
    check("reset_fault", fault, 0);
    rst = 1'b0;
    model_reset();
  endtask

  function automatic void add(input bit h, input bit c, input int n,
                              input int t, input bit s, input bit f);
    vec_t v;
    v.h = h; v.c = c; v.n = n; v.t = t; v.s = s; v.f = f;
    tbl.push_back(v);
  endfunction

  initial begin
    int prev;
    int steps;
    bit h;
    bit c;

    model_reset();
    repeat (2) @(negedge clk);

`ifndef THERMAL_NOISE_EN
    // Directed table. Rows run back to back from reset, and each row's
    // expectation is checked after its last edge.
    add(0, 0,  32, 17, 1, 0);  // first drift step at edge 32
    add(0, 0,  64, 15, 1, 0);  // reaches ambient at edge 96
    add(0, 0,  32, 15, 0, 0);  // holds at ambient
    add(1, 0,   1, 15, 0, 0);  // heat latched
    add(1, 0,   8, 16, 1, 0);  // first heat step PERIOD edges later
    add(1, 1,   1, 16, 0, 1);  // fault on latching edge
    add(1, 1,  19, 16, 0, 1);  // held for 20 cycles in total
    add(0, 0,   1, 16, 0, 0);  // fault clears on leaving edge
    add(0, 0,  32, 15, 1, 0);  // drift restarted from cnt 0
    add(0, 1,   1, 15, 0, 0);  // cool latched
    add(0, 1, 120,  0, 1, 0);  // 15 cool steps reach 0
    add(0, 1,   8,  0, 0, 0);  // saturated at 0, no pulse
    add(1, 0,   1,  0, 0, 0);  // heat latched
    add(1, 0, 248, 31, 1, 0);  // 31 heat steps reach 31
    add(1, 0,  16, 31, 0, 0);  // saturated at 31, no pulse

    do_reset();
    foreach (tbl[i]) begin
      run(tbl[i].h, tbl[i].c, tbl[i].n);
      check($sformatf("tbl%0d_temp", i), temperature, tbl[i].t);
      check($sformatf("tbl%0d_step", i), step, tbl[i].s);
      check($sformatf("tbl%0d_fault", i), fault, tbl[i].f);
    end
`endif

    // Heating from reset: temperature becomes 19 at edge 9 only.
    do_reset();
    run(1, 0, 8);
    check("heat_pre_step", temperature, 18);
    run(1, 0, 1);
    check("heat_edge9_temp", temperature, 19);
    check("heat_edge9_step", step, 1);
    run(1, 0, 1);
    check("heat_step_one_cycle", step, 0);

    // Commands toggling faster than the period freeze the temperature.
    do_reset();
    run(1, 0, 17);
    check("toggle_start", temperature, 20);
    for (int k = 0; k < 50; k++) begin
      run((k % 2) == 1, 0, 4);
    end
    check("toggle_frozen", temperature, 20);

    // Asynchronous reset mid-heat at 25 with cnt=5, between clock edges.
    do_reset();
    run(1, 0, 57);
    check("pre_rst_temp", temperature, 25);
    run(1, 0, 5);
    #1;
    rst = 1'b1;
    #3;
    check("async_rst_temp", temperature, 18);
    check("async_rst_step", step, 0);
    check("async_rst_fault", fault, 0);
    @(negedge clk);
    heating = 1'b0;
    rst = 1'b0;
    model_reset();
    run(0, 0, 32);
    check("post_rst_drift", temperature, 17);

    // Random command segments against the model.
    do_reset();
    for (int k = 0; k < 120; k++) begin
      h = ($urandom_range(0, 2) != 0);
      c = ($urandom_range(0, 2) == 0);
      run(h, c, $urandom_range(1, 45));
    end

`ifdef THERMAL_NOISE_EN
    // Noisy drift from 25 down to ambient: no reversals, no overshoot.
    do_reset();
    run(1, 0, 57);
    check("noise_start", temperature, 25);
    prev  = 25;
    steps = 0;
    for (int k = 0; k < 2000; k++) begin
      run(0, 0, 1);
      check("noise_monotonic", int'(temperature) <= prev, 1);
      check("noise_no_overshoot", int'(temperature) >= AMB_T, 1);
      prev = temperature;
      if (step) steps++;
    end
    check("noise_final", temperature, AMB_T);
    check("noise_steps", steps, 10);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
